deserializer: RTL and testbench

Receive end of the sap3 single-wire serial link. Consumes the LSB-first bit stream and the one-cycle sync pulse from the link transmitter and rebuilds the parallel word. Presents each completed word with a one-cycle valid strobe, and flags frames broken by an early sync pulse. Sits on the consumer side of the link, clocked by the same clk as the transmitter; there is no CDC.

---
 rtl/sap3_serdes_pkg.sv | 11 +
 rtl/deserializer.sv | 84 ++++++++
 tb/tb_deserializer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sap3_serdes_pkg.sv
// Shared definitions for the sap3 single-wire serial link (transmitter and receiver).
package sap3_serdes_pkg;

  localparam int unsigned SERDES_DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

endpackage : sap3_serdes_pkg

// File: rtl/deserializer.sv
// Receive end of the sap3 serial link: rebuilds LSB-first words framed by a one-cycle start pulse.
// Optional saturating aborted-frame counter enabled by defining DESER_ERR_CNT_EN.
module deserializer
  import sap3_serdes_pkg::*;
#(
  parameter int unsigned WIDTH = SERDES_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  input  logic             start,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             busy,
  output logic             frame_err,
  output logic [7:0]       err_count
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shift;

  // Receiver FSM and datapath; strobes default low every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RECV;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        RECV: begin
          if (start) begin
            // Early start wins even on the last-bit edge: resync, drop the partial word
            bit_cnt   <= '0;
            frame_err <= 1'b1;
          end else if (bit_cnt == LAST_BIT) begin
            data_out <= {serial_in, shift[WIDTH-2:0]};
            valid    <= 1'b1;
            bit_cnt  <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            shift[bit_cnt] <= serial_in;
            bit_cnt        <= bit_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DESER_ERR_CNT_EN
  // Counts aborts in step with the frame_err strobe, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (state == RECV && start && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end
`else
  assign err_count = '0;
`endif

endmodule : deserializer

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer (WIDTH=8): directed frames, aborts, reset, sweep.
`timescale 1ns/1ps
module tb_deserializer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         serial_in;
  logic         start;
  logic [W-1:0] data_out;
  logic         valid;
  logic         busy;
  logic         frame_err;
  logic [7:0]   err_count;

  deserializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .serial_in (serial_in),
    .start     (start),
    .data_out  (data_out),
    .valid     (valid),
    .busy      (busy),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_err;
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   seen_errs = 0;
  logic [W-1:0] last_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] exp_err_count(input int errs);
`ifdef DESER_ERR_CNT_EN
    return (errs > 255) ? 8'hFF : 8'(errs);
`else
    return 8'h00;
`endif
  endfunction

  // Monitor: pops the scoreboard whenever a strobe appears
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && frame_err) chk("strobe_overlap", 32'd1, 32'd0);
      if (valid || frame_err) begin
        if (frame_err) seen_errs++;
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {30'd0, valid, frame_err}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("strobe_kind", {31'd0, frame_err}, {31'd0, e.is_err});
          chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
          chk("data_out", 32'(data_out), 32'(e.data));
          chk("err_count", 32'(err_count), 32'(exp_err_count(seen_errs)));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full frame; optionally the start lands while a frame is in progress
  task automatic send_frame(input logic [W-1:0] d, input bit aborts);
    int e;
    start = 1'b1;
    tick();
    e = cyc;
    start = 1'b0;
    if (aborts) exp_q.push_back('{1'b1, last_data, e});
    exp_q.push_back('{1'b0, d, e + int'(W)});
    for (int k = 0; k < int'(W); k++) begin
      serial_in = d[k];
      tick();
    end
    last_data = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      serial_in = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  initial begin
    int e;
    logic [W-1:0] part;
    rst_n = 1'b0;
    start = 1'b0;
    serial_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Single frame 0xA5, busy checked mid-frame and after
    start = 1'b1;
    tick();
    e = cyc;
    start = 1'b0;
    chk("busy_mid", {31'd0, busy}, 32'd1);
    exp_q.push_back('{1'b0, 8'hA5, e + int'(W)});
    part = 8'hA5;
    for (int k = 0; k < int'(W); k++) begin
      serial_in = part[k];
      tick();
    end
    last_data = 8'hA5;
    chk("busy_after_valid", {31'd0, busy}, 32'd0);
    idle(3);

    // Back-to-back at the 10-cycle transmitter rate
    send_frame(8'h3C, 1'b0);
    idle(1);
    send_frame(8'hC3, 1'b0);
    idle(1);
    // Minimum gap: start on the edge right after the last bit
    send_frame(8'h5A, 1'b0);
    send_frame(8'h96, 1'b0);
    idle(3);

    // Early start after 3 bits of 0xFF
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      serial_in = 1'b1;
      tick();
    end
    send_frame(8'h12, 1'b1);
    idle(2);

    // Start on the last-bit edge aborts instead of completing
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < int'(W) - 1; k++) begin
      serial_in = 1'b0;
      tick();
    end
    send_frame(8'h77, 1'b1);
    idle(2);

    // Reset mid-frame after 4 bits
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      serial_in = 1'b1;
      tick();
    end
    rst_n = 1'b0;
    #2;
    chk("midrst_data_out", 32'(data_out), 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("midrst_err_count", 32'(err_count), 32'd0);
    seen_errs = 0;
    last_data = '0;
    tick();
    tick();
    rst_n = 1'b1;
    idle(2);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h81, 1'b0);
    idle(2);

    // 260 consecutive aborts, then finish the frame with zeros
    start = 1'b1;
    tick();
    e = cyc;
    for (int i = 1; i <= 260; i++) begin
      exp_q.push_back('{1'b1, last_data, e + i});
      tick();
    end
    start = 1'b0;
    exp_q.push_back('{1'b0, 8'h00, e + 260 + int'(W)});
    for (int k = 0; k < int'(W); k++) begin
      serial_in = 1'b0;
      tick();
    end
    last_data = 8'h00;
    idle(3);
    chk("err_count_held", 32'(err_count), 32'(exp_err_count(260)));

    // Sweep every byte value at the transmitter rate
    for (int v = 0; v < 256; v++) begin
      send_frame(8'(v), 1'b0);
      idle(1);
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("final_err_count", 32'(err_count), 32'(exp_err_count(260)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_deserializer
